// File: rtl/clock_bringup_pkg.sv
// Shared types and helpers for the clock bring-up sequencer.
package clock_bringup_pkg;

  localparam int unsigned BRINGUP_STATE_W = 3;

  typedef enum logic [BRINGUP_STATE_W-1:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_IDELAY_RST = 3'd3,
    ST_WAIT_RDY   = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } bringup_state_t;

  // Bits needed to count 0..limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module bit_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/clock_bringup_sequencer.sv
// Releases IDELAYCTRL reset and system reset in order once both PLLs are locked,
// re-sequencing on lock loss and latching a fault after repeated calibration failures.
module clock_bringup_sequencer
  import clock_bringup_pkg::*;
#(
  parameter int unsigned LOCK_HOLD_CYCLES  = 1024,
  parameter int unsigned IDELAY_RST_CYCLES = 16,
  parameter int unsigned RDY_TIMEOUT       = 4096,
  parameter int unsigned MAX_RETRIES       = 3,
  parameter int unsigned LOSS_CNT_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 pll_lock,
  input  logic                       idelayctrl_rdy,
  input  logic                       fault_clear,
  output logic                       sys_rst,
  output logic                       idelay_rst,
  output logic                       clocks_ready,
  output logic                       fault,
  output logic [BRINGUP_STATE_W-1:0] state_dbg,
  output logic [LOSS_CNT_WIDTH-1:0]  lock_loss_count,
  output logic [1:0]                 retry_count
);

  localparam int unsigned HOLD_W    = cnt_width(LOCK_HOLD_CYCLES);
  localparam int unsigned PULSE_W   = cnt_width(IDELAY_RST_CYCLES);
  localparam int unsigned TIMEOUT_W = cnt_width(RDY_TIMEOUT);

  logic [2:0] sync_q;
  logic       lock_ok;
  logic       rdy_s;

  bit_synchronizer #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({idelayctrl_rdy, pll_lock}),
    .q     (sync_q)
  );

  assign lock_ok = &sync_q[1:0];
  assign rdy_s   = sync_q[2];

  bringup_state_t           state;
  bringup_state_t           state_nxt;
  logic [HOLD_W-1:0]        hold_cnt;
  logic [PULSE_W-1:0]       pulse_cnt;
  logic [TIMEOUT_W-1:0]     timeout_cnt;

  logic hold_done;
  logic pulse_done;
  logic timeout_done;
  logic last_retry;
  logic lock_lost;
  logic retry_fire;

  assign hold_done    = (hold_cnt == HOLD_W'(LOCK_HOLD_CYCLES - 1));
  assign pulse_done   = (pulse_cnt == PULSE_W'(IDELAY_RST_CYCLES - 1));
  assign timeout_done = (timeout_cnt == TIMEOUT_W'(RDY_TIMEOUT - 1));
  assign last_retry   = (retry_count == 2'(MAX_RETRIES - 1));

  // Lock is only monitored once sequencing has started; FAULT ignores it.
  assign lock_lost  = !lock_ok && (state inside {ST_STABLE, ST_IDELAY_RST, ST_WAIT_RDY, ST_RUN});
  assign retry_fire = !rdy_s && (((state == ST_WAIT_RDY) && timeout_done) || (state == ST_RUN));

  // Next-state selection; later assignments carry higher priority.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:      state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK:  if (lock_ok) state_nxt = ST_STABLE;
      ST_STABLE:     if (hold_done) state_nxt = ST_IDELAY_RST;
      ST_IDELAY_RST: if (pulse_done) state_nxt = ST_WAIT_RDY;
      ST_WAIT_RDY:   if (rdy_s) state_nxt = ST_RUN;
      ST_RUN:        state_nxt = ST_RUN;
      ST_FAULT:      if (fault_clear) state_nxt = ST_WAIT_LOCK;
      default:       state_nxt = ST_RESET;
    endcase
    if (retry_fire) state_nxt = last_retry ? ST_FAULT : ST_IDELAY_RST;
    if (lock_lost)  state_nxt = ST_WAIT_LOCK;
  end

  // State, counters and outputs all update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_RESET;
      hold_cnt        <= '0;
      pulse_cnt       <= '0;
      timeout_cnt     <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      sys_rst         <= 1'b1;
      idelay_rst      <= 1'b1;
      clocks_ready    <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state <= state_nxt;

      hold_cnt    <= ((state == ST_STABLE) && (state_nxt == ST_STABLE))
                     ? hold_cnt + HOLD_W'(1) : '0;
      pulse_cnt   <= ((state == ST_IDELAY_RST) && (state_nxt == ST_IDELAY_RST))
                     ? pulse_cnt + PULSE_W'(1) : '0;
      timeout_cnt <= ((state == ST_WAIT_RDY) && (state_nxt == ST_WAIT_RDY))
                     ? timeout_cnt + TIMEOUT_W'(1) : '0;

      if (state_nxt == ST_WAIT_LOCK) begin
        retry_count <= '0;
      end else if (retry_fire && !last_retry) begin
        retry_count <= retry_count + 2'd1;
      end

      if (lock_lost && (lock_loss_count != '1)) begin
        lock_loss_count <= lock_loss_count + LOSS_CNT_WIDTH'(1);
      end

      sys_rst      <= (state_nxt != ST_RUN);
      idelay_rst   <= !(state_nxt inside {ST_WAIT_RDY, ST_RUN});
      clocks_ready <= (state_nxt == ST_RUN);
      fault        <= (state_nxt == ST_FAULT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_clock_bringup_sequencer.sv
// Directed bench for clock_bringup_sequencer: power-up vector table plus
// hand-written lock-loss, timeout/fault, saturation and reset sequences.
module tb_clock_bringup_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] pll_lock;
  logic       idelayctrl_rdy;
  logic       fault_clear;
  logic       sys_rst;
  logic       idelay_rst;
  logic       clocks_ready;
  logic       fault;
  logic [2:0] state_dbg;
  logic [1:0] lock_loss_count;
  logic [1:0] retry_count;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #4 clk = ~clk;

  clock_bringup_sequencer #(
    .LOCK_HOLD_CYCLES  (16),
    .IDELAY_RST_CYCLES (8),
    .RDY_TIMEOUT       (32),
    .MAX_RETRIES       (3),
    .LOSS_CNT_WIDTH    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .idelayctrl_rdy  (idelayctrl_rdy),
    .fault_clear     (fault_clear),
    .sys_rst         (sys_rst),
    .idelay_rst      (idelay_rst),
    .clocks_ready    (clocks_ready),
    .fault           (fault),
    .state_dbg       (state_dbg),
    .lock_loss_count (lock_loss_count),
    .retry_count     (retry_count)
  );

  typedef struct {
    int at;
    int lock;
    int rdy;
    int st;
    int sys;
    int idr;
    int cr;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, actual, expected);
    end
  endtask

  task automatic expect_outs(input string tag, input int st, input int sys, input int idr,
                             input int cr, input int flt, input int rty, input int loss);
    check({tag, ".state_dbg"},       int'(state_dbg),       st);
    check({tag, ".sys_rst"},         int'(sys_rst),         sys);
    check({tag, ".idelay_rst"},      int'(idelay_rst),      idr);
    check({tag, ".clocks_ready"},    int'(clocks_ready),    cr);
    check({tag, ".fault"},           int'(fault),           flt);
    check({tag, ".retry_count"},     int'(retry_count),     rty);
    check({tag, ".lock_loss_count"}, int'(lock_loss_count), loss);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(state_dbg) == st) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (int'(state_dbg) == st) hit = 1'b1;
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: state_dbg=%0d, expected %0d within %0d cycles", name, state_dbg, st, budget);
    end
  endtask

  task automatic do_reset(input string tag);
    reset          = 1'b1;
    pll_lock       = 2'b00;
    idelayctrl_rdy = 1'b0;
    fault_clear    = 1'b0;
    tick();
    expect_outs(tag, 0, 1, 1, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    n = 0;
  endtask

  task automatic advance_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   falls;
    logic prev_idr;

    // Power-up: locks rise at 10, rdy 3 cycles after idelay_rst falls (at 37).
    vecs[0]  = '{1,  0, 0, 1, 1, 1, 0};
    vecs[1]  = '{10, 3, 0, 1, 1, 1, 0};
    vecs[2]  = '{12, 3, 0, 1, 1, 1, 0};
    vecs[3]  = '{13, 3, 0, 2, 1, 1, 0};
    vecs[4]  = '{28, 3, 0, 2, 1, 1, 0};
    vecs[5]  = '{29, 3, 0, 3, 1, 1, 0};
    vecs[6]  = '{36, 3, 0, 3, 1, 1, 0};
    vecs[7]  = '{37, 3, 0, 4, 1, 0, 0};
    vecs[8]  = '{40, 3, 1, 4, 1, 0, 0};
    vecs[9]  = '{42, 3, 1, 4, 1, 0, 0};
    vecs[10] = '{43, 3, 1, 5, 0, 0, 1};
    vecs[11] = '{50, 3, 1, 5, 0, 0, 1};

    do_reset("rst0");
    foreach (vecs[i]) begin
      advance_to(vecs[i].at);
      expect_outs($sformatf("pwr%0d", vecs[i].at), vecs[i].st, vecs[i].sys, vecs[i].idr,
                  vecs[i].cr, 0, 0, 0);
      pll_lock       = 2'(vecs[i].lock);
      idelayctrl_rdy = 1'(vecs[i].rdy);
    end

    // fault_clear ignored in RUN, then rdy drop triggers a retry.
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    expect_outs("run_fclr", 5, 0, 0, 1, 0, 0, 0);
    idelayctrl_rdy = 1'b0;
    advance_to(53);
    expect_outs("rdyfall53", 5, 0, 0, 1, 0, 0, 0);
    tick();
    expect_outs("rdyfall54", 3, 1, 1, 0, 0, 1, 0);
    idelayctrl_rdy = 1'b1;
    advance_to(62);
    expect_outs("rerdy62", 4, 1, 0, 0, 0, 1, 0);
    tick();
    expect_outs("rerdy63", 5, 0, 0, 1, 0, 1, 0);

    // Lock loss in RUN: pll_lock[0] drops, sys_rst back 3 cycles later.
    pll_lock = 2'b10;
    advance_to(65);
    expect_outs("runloss65", 5, 0, 0, 1, 0, 1, 0);
    tick();
    expect_outs("runloss66", 1, 1, 1, 0, 0, 0, 1);

    // One-cycle glitch on pll_lock[1] during STABLE restarts the hold.
    do_reset("rst1");
    pll_lock = 2'b11;
    advance_to(13);
    pll_lock = 2'b01;
    tick();
    pll_lock = 2'b11;
    advance_to(15);
    expect_outs("glitch15", 2, 1, 1, 0, 0, 0, 0);
    tick();
    expect_outs("glitch16", 1, 1, 1, 0, 0, 0, 1);
    tick();
    expect_outs("glitch17", 2, 1, 1, 0, 0, 0, 1);
    advance_to(32);
    expect_outs("glitch32", 2, 1, 1, 0, 0, 0, 1);
    tick();
    expect_outs("glitch33", 3, 1, 1, 0, 0, 0, 1);

    // rdy never arrives: three calibration pulses then FAULT at 3+16+3*(8+32).
    do_reset("rst2");
    pll_lock = 2'b11;
    falls    = 0;
    prev_idr = idelay_rst;
    for (int i = 0; i < 400; i++) begin
      if (fault) break;
      tick();
      if (prev_idr && !idelay_rst) falls++;
      prev_idr = idelay_rst;
    end
    check("fault_entry_cycle", n, 139);
    check("idelay_pulses", falls, 3);
    expect_outs("fault", 6, 1, 1, 0, 1, 2, 0);
    pll_lock       = 2'b00;
    idelayctrl_rdy = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    expect_outs("fault_hold", 6, 1, 1, 0, 1, 2, 0);
    idelayctrl_rdy = 1'b0;
    fault_clear    = 1'b1;
    tick();
    fault_clear = 1'b0;
    expect_outs("fault_clr", 1, 1, 1, 0, 0, 0, 0);

    // Five lock-loss events saturate a 2-bit counter at 3.
    do_reset("rst3");
    pll_lock = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      wait_state(2, 50, $sformatf("sat_stable%0d", k));
      pll_lock = 2'b00;
      tick();
      pll_lock = 2'b11;
      wait_state(1, 10, $sformatf("sat_waitlock%0d", k));
      check($sformatf("sat_count%0d", k), int'(lock_loss_count), (k < 3) ? k : 3);
    end

    // One-cycle reset while waiting for rdy clears everything, including the loss count.
    wait_state(4, 60, "pre_reset_wait_rdy");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_outs("midrst", 0, 1, 1, 0, 0, 0, 0);
    tick();
    expect_outs("midrst_next", 1, 1, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
